dmem_access_ctrl: RTL and testbench

//  MEM-stage sequencer for the data bus: accepts one load/store per instruction and checks

---
 rtl/dmem_access_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data bus sequencer. Takes one load/store at a
// time from the MEM pipeline register, rejects misaligned accesses, and holds
// a lane-aligned dbus request until data_ok. Load results are lane-extracted
// and sign/zero-extended. A sticky watchdog flags a bus that never answers.

package dmem_access_ctrl_pkg;
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;
endpackage

module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  msize_t      req_msize,
  input  logic        req_unsigned,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output msize_t      dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        stall,
  output logic        done_valid,
  output logic [63:0] load_data,
  output logic        misalign,
  output logic        bus_timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

  // Counter is wide enough to hold TIMEOUT_CYC itself, where it saturates.
  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

  state_t        state, state_next;
  logic [63:0]   addr_q, data_q, load_q;
  msize_t        size_q;
  logic [7:0]    strobe_q;
  logic          unsigned_q, is_store_q, mis_q, timeout_q;
  logic [CW-1:0] wait_cnt;

  logic          accept, aligned;
  logic [7:0]    strobe_calc;
  logic [63:0]   wdata_calc, rshift, load_ext;

  assign accept     = (state == IDLE) && req_valid && !flush;
  assign wdata_calc = req_wdata << {req_addr[2:0], 3'b000};
  assign rshift     = dresp_data >> {addr_q[2:0], 3'b000};

  // Alignment check and byte strobe for the incoming request.
  always_comb begin
    aligned     = 1'b1;
    strobe_calc = 8'hFF;
    case (req_msize)
      MSIZE1: begin
        aligned     = 1'b1;
        strobe_calc = 8'h01 << req_addr[2:0];
      end
      MSIZE2: begin
        aligned     = ~req_addr[0];
        strobe_calc = 8'h03 << {req_addr[2:1], 1'b0};
      end
      MSIZE4: begin
        aligned     = (req_addr[1:0] == 2'b00);
        strobe_calc = 8'h0F << {req_addr[2], 2'b00};
      end
      default: begin
        aligned     = (req_addr[2:0] == 3'b000);
        strobe_calc = 8'hFF;
      end
    endcase
  end

  // Pick the addressed lane out of the read doubleword and extend it.
  always_comb begin
    load_ext = rshift;
    case (size_q)
      MSIZE1:  load_ext = unsigned_q ? {56'd0, rshift[7:0]}
                                     : {{56{rshift[7]}}, rshift[7:0]};
      MSIZE2:  load_ext = unsigned_q ? {48'd0, rshift[15:0]}
                                     : {{48{rshift[15]}}, rshift[15:0]};
      MSIZE4:  load_ext = unsigned_q ? {32'd0, rshift[31:0]}
                                     : {{32{rshift[31]}}, rshift[31:0]};
      default: load_ext = rshift;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic; an issued bus transaction is always seen to completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = aligned ? BUSY : DONE;
      BUSY: begin
        if (dresp_data_ok) state_next = flush ? IDLE : DONE;
        else if (flush)    state_next = DRAIN;
      end
      DRAIN: if (dresp_data_ok) state_next = IDLE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-state handshake outputs.
  always_comb begin
    dreq_valid = 1'b0;
    stall      = 1'b0;
    done_valid = 1'b0;
    misalign   = 1'b0;
    case (state)
      IDLE:  stall = req_valid & ~flush;
      BUSY: begin
        dreq_valid = 1'b1;
        stall      = 1'b1;
      end
      DRAIN: dreq_valid = 1'b1;
      DONE: begin
        done_valid = 1'b1;
        misalign   = mis_q;
      end
      default: ;
    endcase
  end

  // Capture the request on acceptance and the load result on completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      data_q     <= '0;
      size_q     <= MSIZE1;
      strobe_q   <= '0;
      unsigned_q <= 1'b0;
      is_store_q <= 1'b0;
      mis_q      <= 1'b0;
      load_q     <= '0;
    end else begin
      if (accept) begin
        mis_q <= ~aligned;
        if (aligned) begin
          addr_q     <= req_addr;
          data_q     <= wdata_calc;
          size_q     <= req_msize;
          strobe_q   <= strobe_calc;
          unsigned_q <= req_unsigned;
          is_store_q <= req_is_store;
        end
      end
      if (state == BUSY && dresp_data_ok && !flush) load_q <= load_ext;
    end
  end

  // Watchdog: counts cycles spent waiting on the bus, flag is sticky.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (state == BUSY || state == DRAIN) begin
      if (wait_cnt != LIMIT) wait_cnt <= wait_cnt + CW'(1);
      if (TIMEOUT_CYC != 0 && wait_cnt == LIMIT - CW'(1)) timeout_q <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign dreq_addr   = addr_q;
  assign dreq_size   = size_q;
  assign dreq_strobe = is_store_q ? strobe_q : 8'h00;
  assign dreq_data   = data_q;
  assign load_data   = load_q;
  assign bus_timeout = timeout_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: each task drives one scenario and
// compares outputs against hand-computed values. The DUT runs with a short
// watchdog so the timeout can be reached quickly.

module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_is_store = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  msize_t      req_msize = MSIZE1;
  logic        req_unsigned = 1'b0;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  msize_t      dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok = 1'b0;
  logic [63:0] dresp_data = '0;
  logic        stall, done_valid, misalign, bus_timeout;
  logic [63:0] load_data;

  int checks = 0;
  int passed = 0;

  dmem_access_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_is_store(req_is_store), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_msize(req_msize), .req_unsigned(req_unsigned),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .stall(stall), .done_valid(done_valid), .load_data(load_data),
    .misalign(misalign), .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    flush = 0; req_valid = 0; req_is_store = 0; req_addr = '0; req_wdata = '0;
    req_msize = MSIZE1; req_unsigned = 0; dresp_data_ok = 0; dresp_data = '0;
    resetn = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    resetn = 1;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    checks++; if ({dreq_valid, stall, done_valid, misalign, bus_timeout} !== 5'b0)
      $display("[TB] FAIL reset_flags: got %b expected 00000", {dreq_valid, stall, done_valid, misalign, bus_timeout}); else passed++;
    checks++; if (load_data !== 64'h0) $display("[TB] FAIL reset_load_data: got %h expected 0", load_data); else passed++;
    checks++; if ({dreq_addr, dreq_data, dreq_strobe} !== '0)
      $display("[TB] FAIL reset_dreq: got addr %h data %h strobe %h expected zeros", dreq_addr, dreq_data, dreq_strobe); else passed++;
    tick;
  endtask

  task automatic test_lb_zero_wait;
    do_reset;
    req_valid = 1; req_is_store = 0; req_addr = 64'h1003; req_msize = MSIZE1; req_unsigned = 0;
    #1;
    checks++; if (stall !== 1'b1) $display("[TB] FAIL lb_c0_stall: got %b expected 1", stall); else passed++;
    checks++; if (dreq_valid !== 1'b0) $display("[TB] FAIL lb_c0_dreq_valid: got %b expected 0", dreq_valid); else passed++;
    tick;
    dresp_data_ok = 1; dresp_data = 64'h0000_0000_8000_0000;
    #1;
    checks++; if (dreq_valid !== 1'b1 || stall !== 1'b1) $display("[TB] FAIL lb_c1_valid_stall: got %b%b expected 11", dreq_valid, stall); else passed++;
    checks++; if (dreq_addr !== 64'h1003) $display("[TB] FAIL lb_c1_addr: got %h expected 1003", dreq_addr); else passed++;
    checks++; if (dreq_strobe !== 8'h00) $display("[TB] FAIL lb_c1_strobe: got %h expected 00", dreq_strobe); else passed++;
    checks++; if (dreq_size !== MSIZE1) $display("[TB] FAIL lb_c1_size: got %0d expected %0d", dreq_size, MSIZE1); else passed++;
    tick;
    dresp_data_ok = 0;
    #1;
    checks++; if (done_valid !== 1'b1 || stall !== 1'b0 || misalign !== 1'b0)
      $display("[TB] FAIL lb_c2_done: got done %b stall %b mis %b expected 1 0 0", done_valid, stall, misalign); else passed++;
    checks++; if (load_data !== 64'hFFFF_FFFF_FFFF_FF80) $display("[TB] FAIL lb_c2_load_data: got %h expected ffffffffffffff80", load_data); else passed++;
    tick;
    req_valid = 0;
    #1;
    checks++; if (done_valid !== 1'b0) $display("[TB] FAIL lb_c3_done_pulse: got %b expected 0", done_valid); else passed++;
    tick;
  endtask

  task automatic test_sh_held;
    do_reset;
    req_valid = 1; req_is_store = 1; req_addr = 64'h2006; req_msize = MSIZE2; req_wdata = 64'hABCD;
    tick;
    for (int i = 1; i <= 5; i++) begin
      dresp_data_ok = (i == 5);
      #1;
      checks++; if (dreq_valid !== 1'b1 || done_valid !== 1'b0)
        $display("[TB] FAIL sh_busy%0d_valid: got valid %b done %b expected 1 0", i, dreq_valid, done_valid); else passed++;
      checks++; if (dreq_strobe !== 8'hC0) $display("[TB] FAIL sh_busy%0d_strobe: got %h expected c0", i, dreq_strobe); else passed++;
      checks++; if (dreq_data[63:48] !== 16'hABCD) $display("[TB] FAIL sh_busy%0d_data: got %h expected abcd", i, dreq_data[63:48]); else passed++;
      tick;
    end
    dresp_data_ok = 0; req_valid = 0;
    #1;
    checks++; if (done_valid !== 1'b1 || dreq_valid !== 1'b0)
      $display("[TB] FAIL sh_done: got done %b valid %b expected 1 0", done_valid, dreq_valid); else passed++;
    tick;
  endtask

  task automatic test_misalign;
    logic [63:0] ma[3] = '{64'h3002, 64'h0001, 64'h7004};
    msize_t      ms[3] = '{MSIZE4, MSIZE2, MSIZE8};
    do_reset;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1; req_is_store = (i == 1); req_addr = ma[i]; req_msize = ms[i]; req_wdata = 64'h55;
      #1;
      checks++; if (stall !== 1'b1 || dreq_valid !== 1'b0)
        $display("[TB] FAIL mis%0d_c0: got stall %b valid %b expected 1 0", i, stall, dreq_valid); else passed++;
      tick;
      req_valid = 0;
      #1;
      checks++; if (done_valid !== 1'b1 || misalign !== 1'b1 || dreq_valid !== 1'b0)
        $display("[TB] FAIL mis%0d_done: got done %b mis %b valid %b expected 1 1 0", i, done_valid, misalign, dreq_valid); else passed++;
      tick;
      #1;
      checks++; if (done_valid !== 1'b0 || misalign !== 1'b0 || dreq_valid !== 1'b0)
        $display("[TB] FAIL mis%0d_after: got done %b mis %b valid %b expected 0 0 0", i, done_valid, misalign, dreq_valid); else passed++;
      tick;
    end
  endtask

  task automatic test_load_extract;
    logic [63:0] la[7] = '{64'h4004, 64'h4004, 64'h4002, 64'h4002, 64'h4007, 64'h4008, 64'h4000};
    msize_t      lsz[7] = '{MSIZE4, MSIZE4, MSIZE2, MSIZE2, MSIZE1, MSIZE8, MSIZE1};
    logic        lu[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [63:0] ld[7] = '{64'h8765_4321_0000_0000, 64'h8765_4321_0000_0000,
                          64'h0000_0000_8001_0000, 64'h0000_0000_8001_0000,
                          64'hA500_0000_0000_0000, 64'h8123_4567_89AB_CDEF,
                          64'hFFFF_FFFF_FFFF_FF7F};
    logic [63:0] le[7] = '{64'h0000_0000_8765_4321, 64'hFFFF_FFFF_8765_4321,
                          64'hFFFF_FFFF_FFFF_8001, 64'h0000_0000_0000_8001,
                          64'h0000_0000_0000_00A5, 64'h8123_4567_89AB_CDEF,
                          64'h0000_0000_0000_007F};
    do_reset;
    for (int i = 0; i < 7; i++) begin
      req_valid = 1; req_is_store = 0; req_addr = la[i]; req_msize = lsz[i]; req_unsigned = lu[i];
      tick;
      dresp_data_ok = 1; dresp_data = ld[i];
      #1;
      checks++; if (dreq_valid !== 1'b1 || dreq_addr !== la[i])
        $display("[TB] FAIL ld%0d_req: got valid %b addr %h expected 1 %h", i, dreq_valid, dreq_addr, la[i]); else passed++;
      tick;
      dresp_data_ok = 0; req_valid = 0;
      #1;
      checks++; if (done_valid !== 1'b1 || load_data !== le[i])
        $display("[TB] FAIL ld%0d_data: got done %b data %h expected 1 %h", i, done_valid, load_data, le[i]); else passed++;
      tick;
    end
  endtask

  task automatic test_store_lanes;
    logic [63:0] sa[4] = '{64'h5005, 64'h5004, 64'h5000, 64'h5002};
    msize_t      ssz[4] = '{MSIZE1, MSIZE4, MSIZE8, MSIZE2};
    logic [63:0] sw[4] = '{64'h1122_3344_5566_77EE, 64'h0000_0000_DEAD_BEEF,
                          64'h0102_0304_0506_0708, 64'h0000_0000_0000_1234};
    logic [7:0]  sst[4] = '{8'h20, 8'hF0, 8'hFF, 8'h0C};
    logic [63:0] sde[4] = '{64'h0000_EE00_0000_0000, 64'hDEAD_BEEF_0000_0000,
                           64'h0102_0304_0506_0708, 64'h0000_0000_1234_0000};
    logic [63:0] mask;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{sst[i][b]}};
      req_valid = 1; req_is_store = 1; req_addr = sa[i]; req_msize = ssz[i]; req_wdata = sw[i];
      tick;
      dresp_data_ok = 1;
      #1;
      checks++; if (dreq_strobe !== sst[i]) $display("[TB] FAIL st%0d_strobe: got %h expected %h", i, dreq_strobe, sst[i]); else passed++;
      checks++; if ((dreq_data & mask) !== sde[i])
        $display("[TB] FAIL st%0d_data: got %h expected %h", i, dreq_data & mask, sde[i]); else passed++;
      tick;
      dresp_data_ok = 0; req_valid = 0;
      #1;
      checks++; if (done_valid !== 1'b1) $display("[TB] FAIL st%0d_done: got %b expected 1", i, done_valid); else passed++;
      tick;
    end
  endtask

  task automatic test_flush;
    do_reset;
    req_valid = 1; req_is_store = 0; req_addr = 64'h6000; req_msize = MSIZE8; req_unsigned = 0;
    tick;
    #1;
    checks++; if (dreq_valid !== 1'b1) $display("[TB] FAIL fl_busy1: got %b expected 1", dreq_valid); else passed++;
    tick;
    flush = 1;
    #1;
    checks++; if (stall !== 1'b1) $display("[TB] FAIL fl_busy2_stall: got %b expected 1", stall); else passed++;
    tick;
    flush = 0; req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      dresp_data_ok = (i == 2); dresp_data = 64'hDEAD;
      #1;
      checks++; if (dreq_valid !== 1'b1 || stall !== 1'b0 || done_valid !== 1'b0)
        $display("[TB] FAIL fl_drain%0d_ctl: got valid %b stall %b done %b expected 1 0 0", i, dreq_valid, stall, done_valid); else passed++;
      checks++; if (dreq_addr !== 64'h6000 || dreq_size !== MSIZE8)
        $display("[TB] FAIL fl_drain%0d_fields: got addr %h size %0d expected 6000 %0d", i, dreq_addr, dreq_size, MSIZE8); else passed++;
      tick;
    end
    dresp_data_ok = 0;
    #1;
    checks++; if (dreq_valid !== 1'b0 || done_valid !== 1'b0)
      $display("[TB] FAIL fl_idle: got valid %b done %b expected 0 0", dreq_valid, done_valid); else passed++;
    tick;
    // data_ok and flush together in BUSY: result discarded, straight to IDLE.
    req_valid = 1; req_addr = 64'h6008;
    tick;
    dresp_data_ok = 1; flush = 1;
    tick;
    dresp_data_ok = 0; flush = 0; req_valid = 0;
    #1;
    checks++; if (done_valid !== 1'b0 || dreq_valid !== 1'b0 || stall !== 1'b0)
      $display("[TB] FAIL fl_okflush: got done %b valid %b stall %b expected 0 0 0", done_valid, dreq_valid, stall); else passed++;
    tick;
    // Flush in IDLE: nothing accepted.
    req_valid = 1; flush = 1;
    #1;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL fl_idle_stall: got %b expected 0", stall); else passed++;
    tick;
    req_valid = 0; flush = 0;
    #1;
    checks++; if (dreq_valid !== 1'b0) $display("[TB] FAIL fl_idle_noreq: got %b expected 0", dreq_valid); else passed++;
    tick;
  endtask

  task automatic test_back_to_back;
    do_reset;
    req_valid = 1; req_is_store = 0; req_addr = 64'h1003; req_msize = MSIZE1; req_unsigned = 1;
    tick;
    dresp_data_ok = 1; dresp_data = 64'h0000_0000_8000_0000;
    tick;
    dresp_data_ok = 0;
    #1;
    checks++; if (done_valid !== 1'b1 || stall !== 1'b0 || load_data !== 64'h80)
      $display("[TB] FAIL b2b_a_done: got done %b stall %b data %h expected 1 0 80", done_valid, stall, load_data); else passed++;
    tick;
    req_addr = 64'h1010; req_msize = MSIZE8; req_unsigned = 0;
    #1;
    checks++; if (stall !== 1'b1 || dreq_valid !== 1'b0 || done_valid !== 1'b0)
      $display("[TB] FAIL b2b_b_idle: got stall %b valid %b done %b expected 1 0 0", stall, dreq_valid, done_valid); else passed++;
    tick;
    dresp_data_ok = 1; dresp_data = 64'h1122_3344_5566_7788;
    #1;
    checks++; if (dreq_valid !== 1'b1 || dreq_addr !== 64'h1010 || dreq_size !== MSIZE8)
      $display("[TB] FAIL b2b_b_req: got valid %b addr %h size %0d expected 1 1010 %0d", dreq_valid, dreq_addr, dreq_size, MSIZE8); else passed++;
    tick;
    dresp_data_ok = 0; req_valid = 0;
    #1;
    checks++; if (done_valid !== 1'b1 || load_data !== 64'h1122_3344_5566_7788)
      $display("[TB] FAIL b2b_b_done: got done %b data %h expected 1 1122334455667788", done_valid, load_data); else passed++;
    tick;
  endtask

  task automatic test_timeout;
    do_reset;
    req_valid = 1; req_is_store = 0; req_addr = 64'h8000; req_msize = MSIZE8;
    tick;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++; if (bus_timeout !== 1'b0 || dreq_valid !== 1'b1)
        $display("[TB] FAIL to_busy%0d: got timeout %b valid %b expected 0 1", i, bus_timeout, dreq_valid); else passed++;
      tick;
    end
    #1;
    checks++; if (bus_timeout !== 1'b1 || dreq_valid !== 1'b1 || stall !== 1'b1)
      $display("[TB] FAIL to_raised: got timeout %b valid %b stall %b expected 1 1 1", bus_timeout, dreq_valid, stall); else passed++;
    tick;
    #1;
    checks++; if (bus_timeout !== 1'b1) $display("[TB] FAIL to_sticky: got %b expected 1", bus_timeout); else passed++;
    #2;
    req_valid = 0;
    resetn = 0;
    #1;
    checks++; if (dreq_valid !== 1'b0 || bus_timeout !== 1'b0 || stall !== 1'b0 || done_valid !== 1'b0)
      $display("[TB] FAIL to_async_reset: got valid %b timeout %b stall %b done %b expected 0 0 0 0", dreq_valid, bus_timeout, stall, done_valid); else passed++;
    tick;
    resetn = 1;
    tick;
    #1;
    checks++; if (dreq_valid !== 1'b0 || bus_timeout !== 1'b0)
      $display("[TB] FAIL to_after_reset: got valid %b timeout %b expected 0 0", dreq_valid, bus_timeout); else passed++;
  endtask

  // Hard time limit so a broken DUT can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL time_limit: simulation did not finish, got %0d/%0d checks", passed, checks);
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    test_reset;
    test_lb_zero_wait;
    test_sh_held;
    test_misalign;
    test_load_extract;
    test_store_lanes;
    test_flush;
    test_back_to_back;
    test_timeout;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
